// File: rtl/vga_sync_decoder.sv
// Receive-side display timing decoder: recovers pixel coordinates from hsync/vsync/bright
// and verifies line/frame geometry against the nominal mode before reporting lock.
module vga_sync_decoder #(
   parameter int CORDW       = 10,
   parameter int CIDXW       = 3,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             bright,
   input  logic [CIDXW-1:0] pix,
   input  logic             err_clr,
   output logic             de,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic [CIDXW-1:0] pix_o,
   output logic             line_start,
   output logic             frame_start,
   output logic             locked,
   output logic             err,
   output logic [10:0]      h_len,
   output logic [10:0]      v_len
);

   localparam logic [10:0] CNT_MAX  = 11'h7FF;
   localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
   localparam logic [10:0] H_TOT_C  = 11'(H_TOTAL);
   localparam logic [10:0] V_TOT_C  = 11'(V_TOTAL);
   localparam logic [10:0] H_LOST_C = 11'(2 * H_TOTAL);
   localparam logic [7:0]  LOCK_C   = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {HUNT, MEAS, LOCK} state_t;

   state_t           state_q;
   logic [7:0]       goodCnt_q;
   logic             hAct1_q, vAct1_q, hAct2_q, vAct2_q;
   logic             bright1_q, errClr1_q;
   logic [CIDXW-1:0] pix1_q;
   logic [10:0]      hcnt_q, acnt_q, vcnt_q, alines_q;
   logic             frameBad_q;

   logic        hEdge, vEdge, hLost, lineActive, lineBad, frameGood, newErr;
   logic [10:0] hcnt_d, acntBase, acnt_d, vcnt_d, alines_d;
   logic        frameBad_d;

   // Sync levels are stored as "asserted" flags so a reset pipeline never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hAct1_q   <= 1'b0;
         vAct1_q   <= 1'b0;
         hAct2_q   <= 1'b0;
         vAct2_q   <= 1'b0;
         bright1_q <= 1'b0;
         errClr1_q <= 1'b0;
         pix1_q    <= '0;
      end else begin
         hAct1_q   <= (hsync == HSYNC_POL);
         vAct1_q   <= (vsync == VSYNC_POL);
         hAct2_q   <= hAct1_q;
         vAct2_q   <= vAct1_q;
         bright1_q <= bright;
         errClr1_q <= err_clr;
         pix1_q    <= pix;
      end
   end

   always_comb begin
      hEdge      = hAct1_q & ~hAct2_q;
      vEdge      = vAct1_q & ~vAct2_q;
      hLost      = (hcnt_q >= H_LOST_C);
      hcnt_d     = hEdge ? 11'd1 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 11'd1);
      acntBase   = hEdge ? 11'd0 : acnt_q;
      acnt_d     = (bright1_q && (acntBase != CNT_MAX)) ? acntBase + 11'd1 : acntBase;
      lineActive = hEdge && (acnt_q != 11'd0);
      lineBad    = hEdge && (((acnt_q != 11'd0) && (acnt_q != H_ACT_C)) || (hcnt_q != H_TOT_C));
      frameGood  = (vcnt_q == V_TOT_C) && (alines_q == V_ACT_C) && !frameBad_q;
      newErr     = vEdge && !hLost && (state_q == LOCK) && !frameGood;
      // A line whose hsync edge coincides with vsync belongs to the new frame.
      if (vEdge) begin
         vcnt_d     = {10'd0, hEdge};
         alines_d   = {10'd0, lineActive};
         frameBad_d = lineBad;
      end else begin
         vcnt_d     = (hEdge && (vcnt_q != CNT_MAX)) ? vcnt_q + 11'd1 : vcnt_q;
         alines_d   = (lineActive && (alines_q != CNT_MAX)) ? alines_q + 11'd1 : alines_q;
         frameBad_d = frameBad_q | lineBad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q      <= '0;
         acnt_q      <= '0;
         vcnt_q      <= '0;
         alines_q    <= '0;
         frameBad_q  <= 1'b0;
         de          <= 1'b0;
         sx          <= '0;
         sy          <= '0;
         pix_o       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_len       <= '0;
         v_len       <= '0;
      end else begin
         hcnt_q      <= hcnt_d;
         acnt_q      <= acnt_d;
         vcnt_q      <= vcnt_d;
         alines_q    <= alines_d;
         frameBad_q  <= frameBad_d;
         de          <= bright1_q;
         pix_o       <= pix1_q;
         line_start  <= hEdge;
         frame_start <= vEdge;
         if (bright1_q) begin
            sx <= acntBase[CORDW-1:0];
            sy <= alines_d[CORDW-1:0];
         end
         if (hEdge) h_len <= hcnt_q;
         if (vEdge) v_len <= vcnt_q;
      end
   end

   // Lock FSM; losing hsync overrides any frame decision and never flags an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HUNT;
         goodCnt_q <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= (err & ~errClr1_q) | newErr;
         if (hLost) begin
            state_q   <= HUNT;
            goodCnt_q <= '0;
            locked    <= 1'b0;
         end else if (vEdge) begin
            case (state_q)
               HUNT: begin
                  state_q   <= MEAS;
                  goodCnt_q <= '0;
               end
               MEAS: begin
                  if (!frameGood) begin
                     goodCnt_q <= '0;
                  end else begin
                     goodCnt_q <= goodCnt_q + 8'd1;
                     if ((goodCnt_q + 8'd1) >= LOCK_C) begin
                        state_q <= LOCK;
                        locked  <= 1'b1;
                     end
                  end
               end
               LOCK: begin
                  if (!frameGood) begin
                     state_q   <= MEAS;
                     goodCnt_q <= '0;
                     locked    <= 1'b0;
                  end
               end
               default: begin
                  state_q   <= HUNT;
                  goodCnt_q <= '0;
                  locked    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder on a scaled-down video mode, using a
// line/frame-record reference model and randomized fault injection.
module tb_vga_sync_decoder;

   localparam int CORDW        = 10;
   localparam int CIDXW        = 3;
   localparam int H_ACTIVE     = 16;
   localparam int V_ACTIVE     = 6;
   localparam int H_TOTAL      = 24;
   localparam int V_TOTAL      = 10;
   localparam int LOCK_FRAMES  = 2;
   localparam int H_SYNC_START = 18;
   localparam int H_SYNC_END   = 22;
   localparam int V_SYNC_LINE  = 7;

   logic             clk;
   logic             rst_n;
   logic             hsync, vsync, bright, err_clr;
   logic [CIDXW-1:0] pix;
   logic             de, line_start, frame_start, locked, err;
   logic [CORDW-1:0] sx, sy;
   logic [CIDXW-1:0] pix_o;
   logic [10:0]      h_len, v_len;

   vga_sync_decoder #(
      .CORDW(CORDW), .CIDXW(CIDXW), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
      .LOCK_FRAMES(LOCK_FRAMES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .bright(bright),
      .pix(pix), .err_clr(err_clr), .de(de), .sx(sx), .sy(sy), .pix_o(pix_o),
      .line_start(line_start), .frame_start(frame_start), .locked(locked),
      .err(err), .h_len(h_len), .v_len(v_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit de; bit ls; bit fs; bit locked; bit err;
      int pix; int sx; int sy; int hLen; int vLen; int idx;
   } expT;
   typedef struct { int len; int act; } lineRec;

   int nChecks = 0;
   int nFails  = 0;
   int maxSx   = 0;
   int maxSy   = 0;

   expT    expQ[$];
   expT    ce;
   lineRec mLines[$];
   int     mK, mLastH, mCurAct, mActLines, mHLen, mVLen, mStreak;
   bit     mPrevH, mPrevV, mHunting, mLocked, mErr;

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mLines.delete();
      expQ.delete();
      mK = 0; mLastH = -1; mCurAct = 0; mActLines = 0; mHLen = 0; mVLen = 0; mStreak = 0;
      mPrevH = 0; mPrevV = 0; mHunting = 1; mLocked = 0; mErr = 0;
   endtask

   // Drive one input cycle and compute, from line/frame records, what the DUT must show 2 clk later.
   task automatic driveNow(input logic hs, input logic vs, input logic br,
                           input logic [2:0] px, input logic clr);
      expT    e;
      lineRec r;
      bit     hA, vA, hE, vE, lost, good, newErr;
      int     gap;
      hsync = hs; vsync = vs; bright = br; pix = px; err_clr = clr;
      hA = (hs == 1'b0);
      vA = (vs == 1'b0);
      hE = hA && !mPrevH;
      vE = vA && !mPrevV;
      mPrevH = hA;
      mPrevV = vA;
      gap = mK - mLastH;
      if (gap > 2047) gap = 2047;
      lost   = (gap >= 2 * H_TOTAL);
      good   = 0;
      newErr = 0;
      if (vE) begin
         good = (mLines.size() == V_TOTAL) && (mActLines == V_ACTIVE);
         foreach (mLines[i])
            if (mLines[i].len != H_TOTAL || (mLines[i].act != 0 && mLines[i].act != H_ACTIVE))
               good = 0;
         mVLen = (mLines.size() > 2047) ? 2047 : mLines.size();
         mLines.delete();
         mActLines = 0;
      end
      if (lost) begin
         mHunting = 1; mLocked = 0; mStreak = 0;
      end else if (vE) begin
         if (mHunting) begin
            mHunting = 0; mStreak = 0;
         end else if (good) begin
            if (!mLocked) begin
               mStreak++;
               if (mStreak >= LOCK_FRAMES) mLocked = 1;
            end
         end else begin
            if (mLocked) newErr = 1;
            mLocked = 0; mStreak = 0;
         end
      end
      mErr = (mErr && !clr) || newErr;
      if (hE) begin
         r.len = gap;
         r.act = mCurAct;
         mLines.push_back(r);
         if (mCurAct != 0) mActLines++;
         mHLen   = gap;
         mLastH  = mK;
         mCurAct = 0;
      end
      e.sx = mCurAct;
      if (br && mCurAct < 2047) mCurAct++;
      e.sy = mActLines;
      e.de = br; e.pix = int'(px); e.ls = hE; e.fs = vE;
      e.locked = mLocked; e.err = mErr; e.hLen = mHLen; e.vLen = mVLen; e.idx = mK;
      expQ.push_back(e);
      mK++;
   endtask

   task automatic applyStimulus(input logic hs, input logic vs, input logic br,
                                input logic [2:0] px, input logic clr);
      @(posedge clk);
      #1;
      driveNow(hs, vs, br, px, clr);
   endtask

   task automatic releaseReset();
      expT z;
      z = '{default: 0};
      z.idx = -1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expQ.push_back(z);
      expQ.push_back(z);
      driveNow(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic pulseReset();
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("rst_de", int'(de), 0);
      checkOutput("rst_sx", int'(sx), 0);
      checkOutput("rst_sy", int'(sy), 0);
      checkOutput("rst_pix_o", int'(pix_o), 0);
      checkOutput("rst_line_start", int'(line_start), 0);
      checkOutput("rst_frame_start", int'(frame_start), 0);
      checkOutput("rst_locked", int'(locked), 0);
      checkOutput("rst_err", int'(err), 0);
      checkOutput("rst_h_len", int'(h_len), 0);
      checkOutput("rst_v_len", int'(v_len), 0);
      releaseReset();
   endtask

   task automatic driveFrame(input int dropLine, input int dropX, input int stretchLine,
                             input int stretchBy, input int clrLine, input int clrX,
                             input bit ramp, input int rstLine);
      logic       br, hs, vs, clr;
      logic [2:0] px;
      int         len;
      for (int y = 0; y < V_TOTAL; y++) begin
         len = H_TOTAL + ((y == stretchLine) ? stretchBy : 0);
         for (int x = 0; x < len; x++) begin
            br  = (x < H_ACTIVE) && (y < V_ACTIVE) && !(y == dropLine && x == dropX);
            hs  = !(x >= H_SYNC_START && x < H_SYNC_END);
            vs  = !(y == V_SYNC_LINE);
            clr = (y == clrLine) && (x == clrX);
            px  = ramp ? 3'(x) : 3'($urandom);
            applyStimulus(hs, vs, br, px, clr);
            if (y == rstLine && x == 5) begin
               pulseReset();
               return;
            end
         end
      end
   endtask

   task automatic nominal(input int n);
      for (int i = 0; i < n; i++) driveFrame(-1, 0, -1, 0, -1, 0, 1'b0, -1);
   endtask

   task automatic idle(input int n, input logic clr);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, (i == 0) ? clr : 1'b0);
   endtask

   // Cycle-by-cycle comparison against the model, skipping the reset window.
   always @(negedge clk) begin
      if (rst_n && expQ.size() == 3) begin
         ce = expQ.pop_front();
         checkOutput("de", int'(de), int'(ce.de));
         checkOutput("pix_o", int'(pix_o), ce.pix);
         checkOutput("line_start", int'(line_start), int'(ce.ls));
         checkOutput("frame_start", int'(frame_start), int'(ce.fs));
         checkOutput("locked", int'(locked), int'(ce.locked));
         checkOutput("err", int'(err), int'(ce.err));
         checkOutput("h_len", int'(h_len), ce.hLen);
         checkOutput("v_len", int'(v_len), ce.vLen);
         if (ce.de) begin
            checkOutput("sx", int'(sx), ce.sx % (1 << CORDW));
            checkOutput("sy", int'(sy), ce.sy % (1 << CORDW));
         end
         if (de && int'(sx) > maxSx) maxSx = int'(sx);
         if (de && int'(sy) > maxSy) maxSy = int'(sy);
      end
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dropL, strL, clrL;
      rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; bright = 1'b0; pix = '0; err_clr = 1'b0;
      modelReset();
      releaseReset();

      $display("[TB] nominal timing, lock after third vsync edge");
      nominal(2);
      @(negedge clk);
      checkOutput("lit_locked_after_2", int'(locked), 0);
      nominal(1);
      @(negedge clk);
      checkOutput("lit_locked_after_3", int'(locked), 1);
      checkOutput("lit_h_len", int'(h_len), H_TOTAL);
      checkOutput("lit_v_len", int'(v_len), V_TOTAL);
      checkOutput("lit_err_nominal", int'(err), 0);
      checkOutput("lit_max_sx", maxSx, H_ACTIVE - 1);
      checkOutput("lit_max_sy", maxSy, V_ACTIVE - 1);

      $display("[TB] dropped pixel in frame 5, then relock");
      nominal(1);
      driveFrame(3, 7, -1, 0, -1, 0, 1'b0, -1);
      @(negedge clk);
      checkOutput("lit_locked_bad", int'(locked), 0);
      checkOutput("lit_err_bad", int'(err), 1);
      nominal(1);
      @(negedge clk);
      checkOutput("lit_locked_relock1", int'(locked), 0);
      nominal(1);
      @(negedge clk);
      checkOutput("lit_locked_relock2", int'(locked), 1);
      checkOutput("lit_err_sticky", int'(err), 1);

      $display("[TB] hsync lost");
      idle(60, 1'b0);
      @(negedge clk);
      checkOutput("lit_locked_lost", int'(locked), 0);
      checkOutput("lit_err_lost", int'(err), 1);
      idle(4, 1'b1);
      @(negedge clk);
      checkOutput("lit_err_cleared", int'(err), 0);

      $display("[TB] err_clr coincident with bad frame");
      nominal(3);
      @(negedge clk);
      checkOutput("lit_locked_again", int'(locked), 1);
      driveFrame(2, 4, -1, 0, V_SYNC_LINE, 0, 1'b0, -1);
      @(negedge clk);
      checkOutput("lit_err_wins", int'(err), 1);
      checkOutput("lit_locked_drop", int'(locked), 0);

      $display("[TB] reset mid-frame");
      nominal(2);
      @(negedge clk);
      checkOutput("lit_locked_pre_rst", int'(locked), 1);
      driveFrame(-1, 0, -1, 0, -1, 0, 1'b0, 3);
      nominal(2);
      @(negedge clk);
      checkOutput("lit_locked_rst_2", int'(locked), 0);
      nominal(1);
      @(negedge clk);
      checkOutput("lit_locked_rst_3", int'(locked), 1);

      $display("[TB] pixel ramp");
      driveFrame(-1, 0, -1, 0, -1, 0, 1'b1, -1);

      $display("[TB] randomized frames");
      for (int f = 0; f < 24; f++) begin
         int kind;
         kind = $urandom_range(0, 4);
         dropL = -1; strL = -1; clrL = -1;
         if (kind == 1) dropL = $urandom_range(0, V_ACTIVE - 1);
         if (kind == 2) strL  = $urandom_range(0, V_TOTAL - 1);
         if (kind == 3 || kind == 4) clrL = $urandom_range(0, V_TOTAL - 1);
         if (kind == 4) dropL = $urandom_range(0, V_ACTIVE - 1);
         driveFrame(dropL, $urandom_range(0, H_ACTIVE - 1), strL, $urandom_range(1, 3),
                    clrL, $urandom_range(0, H_TOTAL - 1), 1'b0, -1);
      end
      idle(4, 1'b0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
